// File: rtl/text_pkg.sv
// Shared constants, state encoding and helpers for the text write controller.
package text_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [6:0] CHAR_BS    = 7'h08;
    localparam logic [6:0] CHAR_LF    = 7'h0A;
    localparam logic [6:0] CHAR_FF    = 7'h0C;
    localparam logic [6:0] CHAR_CR    = 7'h0D;
    localparam logic [6:0] CHAR_SPACE = 7'h20;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_DECODE    = ST_DECODE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_ACK  = ST_WAIT_ACK,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_FINISH    = ST_FINISH
    } ctrl_state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/text_cursor_step.sv
// Combinational neighbour-cell calculator with row and screen wrap.
module text_cursor_step
    import text_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic [6:0] x,
    input  logic [4:0] y,
    output logic [6:0] fwd_x,
    output logic [4:0] fwd_y,
    output logic [6:0] bwd_x,
    output logic [4:0] bwd_y,
    output logic [4:0] row_next
);

    always_comb begin
        row_next = (y == 5'(ROWS - 1)) ? 5'd0 : y + 5'd1;

        if (x == 7'(COLS - 1)) begin
            fwd_x = 7'd0;
            fwd_y = row_next;
        end else begin
            fwd_x = x + 7'd1;
            fwd_y = y;
        end

        // The origin has no predecessor; callers treat it as a no-op.
        if (x != 7'd0) begin
            bwd_x = x - 7'd1;
            bwd_y = y;
        end else if (y != 5'd0) begin
            bwd_x = 7'(COLS - 1);
            bwd_y = y - 5'd1;
        end else begin
            bwd_x = x;
            bwd_y = y;
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// Turns a character stream into TextBuffer cell writes, tracking a terminal cursor.
// state     | meaning
// IDLE      | in_ready high, waiting for a character
// DECODE    | classify latched character, compute target cell
// ISSUE     | buf_we high for one cycle
// WAIT_ACK  | wait for buf_busy to rise, bounded by ACK_TIMEOUT
// WAIT_DONE | wait for buf_busy to fall; next cell when clearing
// FINISH    | commit the new cursor, back to IDLE
module text_write_ctrl
    import text_pkg::*;
#(
    parameter int          COLS        = COLS_DEF,
    parameter int          ROWS        = ROWS_DEF,
    parameter logic [11:0] CLR_COLOR   = 12'h000,
    parameter int          ACK_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_char,
    input  logic [11:0] in_color,
    input  logic        in_lang,
    output logic        buf_we,
    output logic [6:0]  buf_x,
    output logic [4:0]  buf_y,
    output logic [6:0]  buf_data,
    output logic [11:0] buf_color,
    output logic        buf_lang,
    input  logic        buf_busy,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        clearing
);

    localparam int            TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);

    ctrl_state_t   state;
    logic [6:0]    char_q;
    logic [11:0]   color_q;
    logic          lang_q;
    logic [6:0]    nxt_x;
    logic [4:0]    nxt_y;
    logic [TW-1:0] ack_cnt;

    logic [6:0]    step_x, fwd_x, bwd_x;
    logic [4:0]    step_y, fwd_y, bwd_y, row_next;
    logic          last_cell, at_origin, write_done;

    // One calculator serves the cursor normally and the clear sweep while clearing.
    assign step_x = clearing ? buf_x : cursor_x;
    assign step_y = clearing ? buf_y : cursor_y;

    text_cursor_step #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_step (
        .x        (step_x),
        .y        (step_y),
        .fwd_x    (fwd_x),
        .fwd_y    (fwd_y),
        .bwd_x    (bwd_x),
        .bwd_y    (bwd_y),
        .row_next (row_next)
    );

    assign last_cell  = (buf_x == 7'(COLS - 1)) && (buf_y == 5'(ROWS - 1));
    assign at_origin  = (cursor_x == 7'd0) && (cursor_y == 5'd0);
    assign write_done = !buf_busy &&
                        (((state == S_WAIT_ACK) && (ack_cnt == '0)) || (state == S_WAIT_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            buf_we    <= 1'b0;
            buf_x     <= '0;
            buf_y     <= '0;
            buf_data  <= '0;
            buf_color <= '0;
            buf_lang  <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            clearing  <= 1'b0;
            ack_cnt   <= '0;
            char_q    <= '0;
            color_q   <= '0;
            lang_q    <= 1'b0;
            nxt_x     <= '0;
            nxt_y     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        char_q   <= in_char;
                        color_q  <= in_color;
                        lang_q   <= in_lang;
                        clearing <= (in_char == CHAR_FF);
                        state    <= S_DECODE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= S_FINISH;
                    nxt_x <= cursor_x;
                    nxt_y <= cursor_y;
                    if (is_printable(char_q)) begin
                        buf_x     <= cursor_x;
                        buf_y     <= cursor_y;
                        buf_data  <= char_q;
                        buf_color <= color_q;
                        buf_lang  <= lang_q;
                        nxt_x     <= fwd_x;
                        nxt_y     <= fwd_y;
                        buf_we    <= 1'b1;
                        state     <= S_ISSUE;
                    end else if ((char_q == CHAR_CR) || (char_q == CHAR_LF)) begin
                        nxt_x <= '0;
                        nxt_y <= row_next;
                    end else if ((char_q == CHAR_BS) && !at_origin) begin
                        buf_x     <= bwd_x;
                        buf_y     <= bwd_y;
                        buf_data  <= CHAR_SPACE;
                        buf_color <= color_q;
                        buf_lang  <= lang_q;
                        nxt_x     <= bwd_x;
                        nxt_y     <= bwd_y;
                        buf_we    <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (char_q == CHAR_FF) begin
                        buf_x     <= '0;
                        buf_y     <= '0;
                        buf_data  <= CHAR_SPACE;
                        buf_color <= CLR_COLOR;
                        buf_lang  <= 1'b0;
                        nxt_x     <= '0;
                        nxt_y     <= '0;
                        buf_we    <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    buf_we  <= 1'b0;
                    ack_cnt <= ACK_LOAD;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (buf_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt != '0) begin
                        ack_cnt <= ack_cnt - TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                end
                S_FINISH: begin
                    cursor_x <= nxt_x;
                    cursor_y <= nxt_y;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // A timed-out write completes like an acknowledged one so the sweep never stalls.
            if (write_done) begin
                if (clearing && !last_cell) begin
                    buf_x  <= fwd_x;
                    buf_y  <= fwd_y;
                    buf_we <= 1'b1;
                    state  <= S_ISSUE;
                end else begin
                    clearing <= 1'b0;
                    state    <= S_FINISH;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl with a compliant/mute buffer model and a write scoreboard.
module tb_text_write_ctrl;

    localparam int          COLS = 80;
    localparam int          ROWS = 30;
    localparam logic [11:0] CLR  = 12'h000;

    logic        clk, reset;
    logic        in_valid, in_ready, in_lang;
    logic [6:0]  in_char;
    logic [11:0] in_color;
    logic        buf_we, buf_lang, buf_busy, clearing;
    logic [6:0]  buf_x, buf_data, cursor_x;
    logic [4:0]  buf_y, cursor_y;
    logic [11:0] buf_color;

    text_write_ctrl #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .CLR_COLOR   (CLR),
        .ACK_TIMEOUT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .in_color  (in_color),
        .in_lang   (in_lang),
        .buf_we    (buf_we),
        .buf_x     (buf_x),
        .buf_y     (buf_y),
        .buf_data  (buf_data),
        .buf_color (buf_color),
        .buf_lang  (buf_lang),
        .buf_busy  (buf_busy),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .clearing  (clearing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer model: busy rises the cycle after write_enable and stays high two cycles.
    logic       busy_en;
    logic [1:0] bcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_busy <= 1'b0;
            bcnt     <= 2'd0;
        end else if (buf_we && busy_en) begin
            buf_busy <= 1'b1;
            bcnt     <= 2'd1;
        end else if (bcnt != 2'd0) begin
            bcnt <= bcnt - 2'd1;
        end else begin
            buf_busy <= 1'b0;
        end
    end

    wire [31:0] fields = {buf_x, buf_y, buf_data, buf_color, buf_lang};

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_we  = 0;
    logic [31:0] exp_q[$];
    logic        exp_clr = 1'b0;
    int          mx = 0;
    int          my = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic        hold_pend = 1'b0;
    logic [31:0] hold_val;
    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("hold_after_we", fields, hold_val);
            hold_pend = buf_we;
            hold_val  = fields;
            if (buf_we) begin
                n_we++;
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_write observed=%0h expected=none", fields);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("write_cell", fields, mon_e);
                end
                chk("clear_ready_flags", {clearing, in_ready}, {exp_clr, 1'b0});
            end
        end
    end

    task automatic push_w(input int x, input int y, input logic [6:0] d,
                          input logic [11:0] col, input logic l);
        exp_q.push_back({7'(x), 5'(y), d, col, l});
    endtask

    task automatic model(input logic [6:0] c, input logic [11:0] col, input logic l);
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_w(mx, my, c, col, l);
            if (mx == COLS - 1) begin
                mx = 0;
                my = (my == ROWS - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end else if (c == 7'h0D || c == 7'h0A) begin
            mx = 0;
            my = (my == ROWS - 1) ? 0 : my + 1;
        end else if (c == 7'h08) begin
            if (mx > 0 || my > 0) begin
                if (mx > 0) mx = mx - 1;
                else begin
                    mx = COLS - 1;
                    my = my - 1;
                end
                push_w(mx, my, 7'h20, col, l);
            end
        end else if (c == 7'h0C) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    push_w(x, y, 7'h20, CLR, 1'b0);
            mx = 0;
            my = 0;
        end
    endtask

    task automatic send(input logic [6:0] c, input logic [11:0] col, input logic l);
        in_valid = 1'b1;
        in_char  = c;
        in_color = col;
        in_lang  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (in_ready !== 1'b1 && lat < 12000);
        n_cmp++;
        assert (in_ready === 1'b1) else begin
            n_err++;
            $error("FAIL ready_timeout observed=%b expected=1", in_ready);
        end
    endtask

    task automatic do_char(input logic [6:0] c, input logic [11:0] col, input logic l,
                           output int lat);
        model(c, col, l);
        send(c, col, l);
        wait_ready(lat);
        chk("cursor_model", {cursor_x, cursor_y}, {7'(mx), 5'(my)});
    endtask

    initial begin
        int lat;
        int w0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = '0;
        in_color = '0;
        in_lang  = 1'b0;
        busy_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_fields", fields, 0);
        chk("rst_cursor", {cursor_x, cursor_y}, 0);
        chk("rst_clearing", clearing, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(lat);

        w0 = n_we;
        do_char(7'h41, 12'hF00, 1'b0, lat);
        chk("A_latency", lat, 6);
        chk("A_one_write", n_we - w0, 1);
        chk("A_cursor", {cursor_x, cursor_y}, {7'd1, 5'd0});

        do_char(7'h62, 12'h0F0, 1'b1, lat);
        do_char(7'h7E, 12'h00F, 1'b0, lat);
        do_char(7'h20, 12'h123, 1'b1, lat);

        w0 = n_we;
        do_char(7'h07, 12'hFFF, 1'b1, lat);
        do_char(7'h7F, 12'hFFF, 1'b1, lat);
        do_char(7'h00, 12'hFFF, 1'b1, lat);
        chk("ctrl_no_write", n_we - w0, 0);
        chk("ctrl_cursor", {cursor_x, cursor_y}, {7'd4, 5'd0});

        for (int i = 0; i < 12; i++) do_char(7'h0D, 12'h000, 1'b0, lat);
        for (int i = 0; i < 37; i++) do_char(7'(97 + (i % 26)), 12'h3C5, 1'(i % 2), lat);
        chk("pre_cr_cursor", {cursor_x, cursor_y}, {7'd37, 5'd12});
        w0 = n_we;
        do_char(7'h0D, 12'h000, 1'b0, lat);
        chk("cr_cursor", {cursor_x, cursor_y}, {7'd0, 5'd13});
        do_char(7'h0A, 12'h000, 1'b0, lat);
        chk("lf_cursor", {cursor_x, cursor_y}, {7'd0, 5'd14});
        chk("crlf_no_write", n_we - w0, 0);

        for (int i = 0; i < 21; i++) do_char(7'h0A, 12'h000, 1'b0, lat);
        chk("lf_wrap_cursor", {cursor_x, cursor_y}, {7'd0, 5'd5});
        w0 = n_we;
        do_char(7'h08, 12'h0AB, 1'b1, lat);
        chk("bs_latency", lat, 6);
        chk("bs_one_write", n_we - w0, 1);
        chk("bs_row_cursor", {cursor_x, cursor_y}, {7'd79, 5'd4});
        do_char(7'h08, 12'h456, 1'b0, lat);
        do_char(7'h51, 12'h789, 1'b1, lat);

        for (int i = 0; i < 25; i++) do_char(7'h0D, 12'h000, 1'b0, lat);
        for (int i = 0; i < 79; i++) do_char(7'(65 + (i % 26)), 12'hE1E, 1'b0, lat);
        chk("last_cell_cursor", {cursor_x, cursor_y}, {7'd79, 5'd29});
        w0 = n_we;
        do_char(7'h5A, 12'h0FF, 1'b1, lat);
        chk("wrap_one_write", n_we - w0, 1);
        chk("wrap_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});

        w0 = n_we;
        do_char(7'h08, 12'h111, 1'b0, lat);
        chk("bs_origin_no_write", n_we - w0, 0);
        chk("bs_origin_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});

        do_char(7'h78, 12'h222, 1'b0, lat);
        do_char(7'h79, 12'h333, 1'b1, lat);
        w0      = n_we;
        exp_clr = 1'b1;
        do_char(7'h0C, 12'hFFF, 1'b1, lat);
        exp_clr = 1'b0;
        chk("clear_writes", n_we - w0, COLS * ROWS);
        chk("clear_latency", lat, 2 + 4 * COLS * ROWS);
        chk("clear_cursor", {cursor_x, cursor_y}, {7'd0, 5'd0});
        chk("clear_done_flag", clearing, 0);
        chk("clear_queue_empty", exp_q.size(), 0);

        busy_en = 1'b0;
        w0 = n_we;
        do_char(7'h54, 12'hA5A, 1'b0, lat);
        chk("timeout_latency", lat, 6);
        chk("timeout_cursor", {cursor_x, cursor_y}, {7'd1, 5'd0});
        do_char(7'h55, 12'h5A5, 1'b1, lat);
        chk("timeout_writes", n_we - w0, 2);
        busy_en = 1'b1;

        exp_clr = 1'b1;
        model(7'h0C, 12'h000, 1'b0);
        send(7'h0C, 12'h000, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midclr_in_ready", in_ready, 0);
        chk("midclr_buf_we", buf_we, 0);
        chk("midclr_fields", fields, 0);
        chk("midclr_cursor", {cursor_x, cursor_y}, 0);
        chk("midclr_clearing", clearing, 0);
        exp_q.delete();
        exp_clr = 1'b0;
        mx = 0;
        my = 0;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(lat);
        do_char(7'h6B, 12'hABC, 1'b1, lat);
        chk("post_reset_cursor", {cursor_x, cursor_y}, {7'd1, 5'd0});
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
